seq_debug_mailbox: RTL and testbench

- Sequencer-side responder for the sequencer core debug command mailbox. A host such as the debug toolkit or a testbench initiator writes a command and parameters over Avalon-MM at the debug base address, then polls the status word.
- This block holds those registers and presents the command to the sequencer core with a valid/ready handshake.
- It captures the core's completion result, which the host reads and then acknowledges.

---
 rtl/seq_debug_mailbox_pkg.sv | 39 +++
 rtl/seq_debug_param_bank.sv | 43 ++++
 rtl/seq_debug_mailbox.sv | 168 ++++++++++++++++
 tb/tb_seq_debug_mailbox.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_debug_mailbox_pkg.sv
// Shared types and register-map constants for the sequencer debug mailbox.
// Imported by the mailbox top level and its parameter bank.
package seq_debug_mailbox_pkg;

    typedef enum logic [3:0] {
        ST_NONE     = 4'd0,
        ST_PENDING  = 4'd1,
        ST_ACTIVE   = 4'd2,
        ST_DONE_OK  = 4'd3,
        ST_DONE_ERR = 4'd4
    } status_code_e;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACTIVE,
        DONE
    } state_e;

    localparam int unsigned GBL_OFS        = 'h0;
    localparam int unsigned REQ_CMD_OFS    = 'h8;
    localparam int unsigned CMD_STATUS_OFS = 'hC;
    localparam int unsigned PARAMS_OFS     = 'h10;
    localparam int unsigned OVERRUN_BIT    = 8;

    function automatic status_code_e state_code(
        input state_e s,
        input logic   err
    );
        case (s)
            IDLE:    return ST_NONE;
            PENDING: return ST_PENDING;
            ACTIVE:  return ST_ACTIVE;
            DONE:    return err ? ST_DONE_ERR : ST_DONE_OK;
            default: return ST_NONE;
        endcase
    endfunction

endpackage

// File: rtl/seq_debug_param_bank.sv
// Parameter word registers for the debug mailbox, with a read port
// and a snapshot copy that stays frozen while a command is in flight.
module seq_debug_param_bank
    import seq_debug_mailbox_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_PARAMS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         snap_en,
    output logic [NUM_PARAMS*DATA_W-1:0] snap
);

    logic [DATA_W-1:0] regs [NUM_PARAMS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                regs[i] <= '0;
            end
            snap <= '0;
        end else begin
            if (wr_en) begin
                regs[wr_idx] <= wr_data;
            end
            if (snap_en) begin
                for (int i = 0; i < NUM_PARAMS; i++) begin
                    snap[i*DATA_W +: DATA_W] <= regs[i];
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/seq_debug_mailbox.sv
// Avalon-MM debug command mailbox: host-written command and parameters
// are handed to the sequencer core and its completion status captured.
module seq_debug_mailbox
    import seq_debug_mailbox_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                CMD_W      = 8,
    parameter int                NUM_PARAMS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h000153b4,
    parameter logic [DATA_W-1:0] GBL_ADDR   = 'h00015388
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            avl_address,
    input  logic                         avl_read,
    input  logic                         avl_write,
    input  logic [DATA_W-1:0]            avl_writedata,
    output logic [DATA_W-1:0]            avl_readdata,
    output logic                         avl_readdatavalid,
    output logic                         avl_waitrequest,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [CMD_W-1:0]             cmd_id,
    output logic [NUM_PARAMS*DATA_W-1:0] cmd_params,
    input  logic                         rsp_valid,
    input  logic                         rsp_err,
    output logic                         busy
);

    localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
    localparam int unsigned PARAMS_END = PARAMS_OFS + 4 * NUM_PARAMS;

    state_e            state;
    logic [CMD_W-1:0]  req_cmd;
    logic              overrun;
    logic              done_err;

    logic [ADDR_W-1:0] ofs;
    logic [ADDR_W-1:0] par_ofs;
    logic [IDX_W-1:0]  par_idx;
    logic              gbl_hit;
    logic              cmd_hit;
    logic              sts_hit;
    logic              par_hit;
    logic              cmd_wr;
    logic              sts_wr;
    logic              par_wr;
    logic              cmd_nz;
    logic              launch;
    logic [DATA_W-1:0] par_rd;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_mux;

    assign ofs     = avl_address - BASE_ADDR;
    assign par_ofs = ofs - ADDR_W'(PARAMS_OFS);
    assign par_idx = IDX_W'(par_ofs >> 2);

    assign gbl_hit = (ofs == ADDR_W'(GBL_OFS));
    assign cmd_hit = (ofs == ADDR_W'(REQ_CMD_OFS));
    assign sts_hit = (ofs == ADDR_W'(CMD_STATUS_OFS));
    assign par_hit = (ofs >= ADDR_W'(PARAMS_OFS))
                   && (ofs < ADDR_W'(PARAMS_END))
                   && (ofs[1:0] == 2'b00);

    assign cmd_wr = avl_write && cmd_hit;
    assign sts_wr = avl_write && sts_hit;
    assign par_wr = avl_write && par_hit;
    assign cmd_nz = (avl_writedata[CMD_W-1:0] != '0);
    assign launch = (state == IDLE) && cmd_wr && cmd_nz;

    assign avl_waitrequest = 1'b0;
    assign cmd_id          = req_cmd;

    seq_debug_param_bank #(
        .DATA_W     (DATA_W),
        .NUM_PARAMS (NUM_PARAMS),
        .IDX_W      (IDX_W)
    ) u_param_bank (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (par_wr && (state == IDLE)),
        .wr_idx  (par_idx),
        .wr_data (avl_writedata),
        .rd_idx  (par_idx),
        .rd_data (par_rd),
        .snap_en (launch),
        .snap    (cmd_params)
    );

    always_comb begin
        status_word              = '0;
        status_word[3:0]         = state_code(state, done_err);
        status_word[OVERRUN_BIT] = overrun;
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            gbl_hit: rd_mux = GBL_ADDR;
            cmd_hit: rd_mux = DATA_W'(req_cmd);
            sts_hit: rd_mux = status_word;
            par_hit: rd_mux = par_rd;
            default: rd_mux = '0;
        endcase
    end

    // Read data is taken from pre-edge state, so a same-cycle write
    // lands after the read has captured its value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avl_readdata      <= '0;
            avl_readdatavalid <= 1'b0;
        end else begin
            avl_readdatavalid <= avl_read;
            avl_readdata      <= avl_read ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_cmd   <= '0;
            overrun   <= 1'b0;
            done_err  <= 1'b0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= PENDING;
                        req_cmd   <= avl_writedata[CMD_W-1:0];
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PENDING: begin
                    if (cmd_ready) begin
                        state     <= ACTIVE;
                        cmd_valid <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (rsp_valid) begin
                        state    <= DONE;
                        done_err <= rsp_err;
                    end
                end
                DONE: begin
                    if (sts_wr) begin
                        state   <= IDLE;
                        req_cmd <= '0;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if ((state == DONE) && sts_wr) begin
                overrun <= 1'b0;
            end else if ((state != IDLE) && (cmd_wr || par_wr)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_debug_mailbox.sv
// Self-checking bench for seq_debug_mailbox: directed scenarios plus
// randomized command traffic checked against a register-level model.
module tb_seq_debug_mailbox;

    localparam logic [31:0] BASE = 32'h000153b4;
    localparam logic [31:0] GBL  = 32'h00015388;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  avl_address = '0;
    logic         avl_read = 1'b0;
    logic         avl_write = 1'b0;
    logic [31:0]  avl_writedata = '0;
    logic [31:0]  avl_readdata;
    logic         avl_readdatavalid;
    logic         avl_waitrequest;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic [7:0]   cmd_id;
    logic [127:0] cmd_params;
    logic         rsp_valid = 1'b0;
    logic         rsp_err = 1'b0;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    int           m_code;
    logic [7:0]   m_cmd;
    logic [31:0]  m_par [4];
    logic         m_ovr;
    logic [127:0] m_snap;

    always #5 clk = ~clk;

    seq_debug_mailbox dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .avl_waitrequest   (avl_waitrequest),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_id            (cmd_id),
        .cmd_params        (cmd_params),
        .rsp_valid         (rsp_valid),
        .rsp_err           (rsp_err),
        .busy              (busy)
    );

    function automatic void mdl_reset();
        m_code = 0;
        m_cmd  = '0;
        m_ovr  = 1'b0;
        m_snap = '0;
        for (int i = 0; i < 4; i++) m_par[i] = '0;
    endfunction

    function automatic void mdl_write(input logic [31:0] a,
                                      input logic [31:0] d);
        logic [31:0] o;
        o = a - BASE;
        if (o == 32'h8) begin
            if (m_code != 0) m_ovr = 1'b1;
            else if (d[7:0] != 8'h0) begin
                m_cmd  = d[7:0];
                m_code = 1;
                for (int i = 0; i < 4; i++) m_snap[i*32 +: 32] = m_par[i];
            end
        end else if (o == 32'hC) begin
            if (m_code >= 3) begin
                m_code = 0;
                m_cmd  = '0;
                m_ovr  = 1'b0;
            end
        end else if (o >= 32'h10 && o < 32'h20 && o[1:0] == 2'b00) begin
            if (m_code == 0) m_par[(o - 32'h10) >> 2] = d;
            else m_ovr = 1'b1;
        end
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (o == 32'h0) return GBL;
        if (o == 32'h8) return {24'h0, m_cmd};
        if (o == 32'hC) return {23'h0, m_ovr, 4'h0, 4'(m_code)};
        if (o >= 32'h10 && o < 32'h20 && o[1:0] == 2'b00)
            return m_par[(o - 32'h10) >> 2];
        return 32'h0;
    endfunction

    task automatic avl_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        avl_address   = a;
        avl_writedata = d;
        avl_write     = 1'b1;
        @(negedge clk);
        avl_write     = 1'b0;
        mdl_write(a, d);
    endtask

    task automatic avl_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic v);
        @(negedge clk);
        avl_address = a;
        avl_read    = 1'b1;
        @(negedge clk);
        avl_read    = 1'b0;
        d = avl_readdata;
        v = avl_readdatavalid;
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        if (m_code == 1) m_code = 2;
    endtask

    task automatic pulse_rsp(input logic e);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_err   = e;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        if (m_code == 2) m_code = e ? 4 : 3;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset_n = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cmd_valid, busy, cmd_id, cmd_params, avl_readdatavalid,
             avl_waitrequest, avl_readdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b busy=%b id=%h rdv=%b wr=%b, required all 0",
                     cmd_valid, busy, cmd_id, avl_readdatavalid, avl_waitrequest);
        end
        avl_rd(BASE, d, v);
        vectors++;
        if ({v, d} !== {1'b1, GBL}) begin
            miscompares++;
            $display("FAIL reset_gbl: v=%b d=%h, required v=1 d=%h", v, d, GBL);
        end
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_status: v=%b d=%h, required v=1 d=0", v, d);
        end
    endtask

    task automatic test_command();
        logic [31:0] d;
        logic        v;
        avl_wr(BASE + 32'h10, 32'hDEADBEEF);
        avl_wr(BASE + 32'h14, 32'h5);
        @(negedge clk);
        avl_address   = BASE + 32'h8;
        avl_writedata = 32'h12;
        avl_write     = 1'b1;
        @(negedge clk);
        avl_write     = 1'b0;
        mdl_write(BASE + 32'h8, 32'h12);
        vectors++;
        if ({cmd_valid, cmd_id, cmd_params[63:0]} !==
            {1'b1, 8'h12, 64'h00000005_DEADBEEF}) begin
            miscompares++;
            $display("FAIL cmd_launch: valid=%b id=%h params=%h, required 1 12 00000005deadbeef",
                     cmd_valid, cmd_id, cmd_params[63:0]);
        end
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL status_pending: got %h required 1", d);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({cmd_valid, cmd_id, cmd_params} !== {1'b1, 8'h12, m_snap}) begin
                miscompares++;
                $display("FAIL hold_stable: valid=%b id=%h, required 1 12", cmd_valid, cmd_id);
            end
        end
        pulse_ready();
        vectors++;
        if (cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_drop: got %b required 0", cmd_valid);
        end
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL status_active: got %h required 2", d);
        end
        pulse_rsp(1'b1);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h4) begin
            miscompares++;
            $display("FAIL status_done_err: got %h required 4", d);
        end
        avl_wr(BASE + 32'hC, 32'h0);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if ({d, busy} !== {32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL ack_status: status=%h busy=%b, required 0 0", d, busy);
        end
        avl_rd(BASE + 32'h8, d, v);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL ack_req_cmd: got %h required 0", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic        v;
        avl_wr(BASE + 32'h8, 32'h21);
        pulse_ready();
        avl_wr(BASE + 32'h10, 32'h1);
        avl_wr(BASE + 32'h8, 32'h7);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h102) begin
            miscompares++;
            $display("FAIL overrun_status: got %h required 102", d);
        end
        avl_rd(BASE + 32'h10, d, v);
        vectors++;
        if (d !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL overrun_param0: got %h required deadbeef", d);
        end
        vectors++;
        if ({cmd_id, cmd_params} !== {8'h21, m_snap}) begin
            miscompares++;
            $display("FAIL overrun_snapshot: id=%h params=%h, required 21 %h",
                     cmd_id, cmd_params, m_snap);
        end
        pulse_rsp(1'b0);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h103) begin
            miscompares++;
            $display("FAIL overrun_done: got %h required 103", d);
        end
        avl_wr(BASE + 32'hC, 32'h0);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL overrun_ack: got %h required 0", d);
        end
    endtask

    task automatic test_edges();
        logic [31:0] d;
        logic        v;
        logic [31:0] old;
        avl_wr(BASE + 32'h8, 32'hFFFFFF00);
        vectors++;
        if ({cmd_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_cmd: valid=%b busy=%b, required 0 0", cmd_valid, busy);
        end
        pulse_rsp(1'b1);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== mdl_read(BASE + 32'hC)) begin
            miscompares++;
            $display("FAIL rsp_idle: got %h required %h", d, mdl_read(BASE + 32'hC));
        end
        avl_rd(32'h00015500, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL out_of_map: v=%b d=%h, required 1 0", v, d);
        end
        avl_rd(BASE + 32'h4, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL reserved: v=%b d=%h, required 1 0", v, d);
        end
        old = m_par[2];
        @(negedge clk);
        avl_address   = BASE + 32'h18;
        avl_writedata = 32'hA5A5_0F0F;
        avl_read      = 1'b1;
        avl_write     = 1'b1;
        @(negedge clk);
        avl_read      = 1'b0;
        avl_write     = 1'b0;
        mdl_write(BASE + 32'h18, 32'hA5A5_0F0F);
        vectors++;
        if ({avl_readdatavalid, avl_readdata} !== {1'b1, old}) begin
            miscompares++;
            $display("FAIL rw_same_cycle: v=%b d=%h, required 1 %h",
                     avl_readdatavalid, avl_readdata, old);
        end
        avl_rd(BASE + 32'h18, d, v);
        vectors++;
        if (d !== 32'hA5A5_0F0F) begin
            miscompares++;
            $display("FAIL rw_write_won: got %h required a5a50f0f", d);
        end
        avl_wr(BASE + 32'h8, 32'h3C);
        @(negedge clk);
        cmd_ready = 1'b1;
        rsp_valid = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        if (m_code == 1) m_code = 2;
        avl_wr(BASE + 32'hC, 32'hFFFFFFFF);
        avl_rd(BASE + 32'hC, d, v);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL rsp_with_ready_ack_active: got %h required 2", d);
        end
        pulse_rsp(1'b0);
        avl_wr(BASE + 32'hC, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        v;
        logic [31:0] a;
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1)
                    avl_wr(BASE + 32'h10 + 32'(4 * k), $urandom);
            end
            avl_wr(BASE + 32'h8, {24'($urandom), 8'($urandom_range(1, 255))});
            vectors++;
            if ({cmd_valid, cmd_id, cmd_params} !== {1'b1, m_cmd, m_snap}) begin
                miscompares++;
                $display("FAIL rnd_launch it=%0d: valid=%b id=%h, required 1 %h",
                         it, cmd_valid, cmd_id, m_cmd);
            end
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = ($urandom_range(0, 1) == 1) ? BASE + 32'h8 :
                        BASE + 32'h10 + 32'(4 * $urandom_range(0, 3));
                    avl_wr(a, $urandom);
                end else begin
                    @(negedge clk);
                end
            end
            pulse_ready();
            if ($urandom_range(0, 1) == 1) avl_wr(BASE + 32'hC, $urandom);
            pulse_rsp(1'($urandom_range(0, 1)));
            for (int r = 0; r < 8; r++) begin
                avl_rd(BASE + 32'(4 * r), d, v);
                vectors++;
                if ({v, d} !== {1'b1, mdl_read(BASE + 32'(4 * r))}) begin
                    miscompares++;
                    $display("FAIL rnd_read it=%0d ofs=%h: v=%b d=%h, required 1 %h",
                             it, 4 * r, v, d, mdl_read(BASE + 32'(4 * r)));
                end
            end
            vectors++;
            if ({cmd_valid, busy, cmd_params} !== {1'b0, 1'b1, m_snap}) begin
                miscompares++;
                $display("FAIL rnd_done it=%0d: valid=%b busy=%b, required 0 1",
                         it, cmd_valid, busy);
            end
            avl_wr(BASE + 32'hC, $urandom);
            avl_rd(BASE + 32'hC, d, v);
            vectors++;
            if ({d, busy} !== {32'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL rnd_ack it=%0d: status=%h busy=%b, required 0 0", it, d, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        avl_wr(BASE + 32'h1C, 32'h1234_5678);
        avl_wr(BASE + 32'h8, 32'h55);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        mdl_reset();
        #1;
        vectors++;
        if ({cmd_valid, busy, cmd_id, cmd_params} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_async: valid=%b busy=%b id=%h, required 0 0 0",
                     cmd_valid, busy, cmd_id);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            avl_rd(BASE + 32'(4 * r), d, v);
            vectors++;
            if ({v, d} !== {1'b1, mdl_read(BASE + 32'(4 * r))}) begin
                miscompares++;
                $display("FAIL reset_mid_read ofs=%h: v=%b d=%h, required 1 %h",
                         4 * r, v, d, mdl_read(BASE + 32'(4 * r)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, required finish before 200us");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_command();
        test_overrun();
        test_edges();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
